control_unit_mc: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle control unit.
- Owns the program counter and instruction register, and sequences FETCH/DECODE/EXEC states with a memory-ready handshake.
- Drives the same bus/register-file control strobes per execute cycle.
- Sits between instruction memory and the datapath (register file, ALU A/C registers, constant generator).

---
 rtl/control_unit_mc.sv | 169 ++++++++++++++++
 tb/tb_control_unit_mc.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/control_unit_mc.sv
// control_unit_mc: multi-cycle control unit. Owns the PC and IR and steps
// through FETCH / DECODE / EX1 / EX2 states, plus JMP_TGT for reading a jump
// operand and HALT. Instruction reads use a memRdy handshake. Outputs depend
// only on state and IR.
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to trap undefined opcodes
// into HALT and raise the sticky illegal flag. Without it, undefined opcodes
// execute as NOP and illegal is tied low.
module control_unit_mc #(
    parameter int ADDR_W = 8,
    parameter int INST_W = 8,
    parameter int SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] inst,
    input  logic              memRdy,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memRd,
    output logic [SEL_W-1:0]  regSel,
    output logic [SEL_W-1:0]  aluSel,
    output logic              Rin,
    output logic              Rout,
    output logic              RAin,
    output logic              RCout,
    output logic              genConst,
    output logic              halted,
    output logic              illegal
);

    localparam int OP_W = INST_W - SEL_W;

    localparam logic [OP_W-1:0] OP_NOP  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_MOVA = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ALU  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_LDC  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_MOVR = OP_W'(4);
    localparam logic [OP_W-1:0] OP_JMP  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_HALT = '1;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_JMP_TGT,
        S_EX1,
        S_EX2,
        S_HALT
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   pc;
    logic [INST_W-1:0]   ir;
    logic [OP_W-1:0]     opcode;
    logic [SEL_W-1:0]    operand;

    assign opcode  = ir[INST_W-1:SEL_W];
    assign operand = ir[SEL_W-1:0];
    assign memAddr = pc;

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic undef_op;
    assign undef_op = !(opcode inside {OP_NOP, OP_MOVA, OP_ALU, OP_LDC,
                                       OP_MOVR, OP_JMP, OP_HALT});

    // Sticky illegal flag, set when an undefined opcode is decoded
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            illegal <= 1'b0;
        else if (state == S_DECODE && undef_op)
            illegal <= 1'b1;
    end
`else
    assign illegal = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_FETCH;
        else
            state <= next_state;
    end

    // PC and IR: load on a ready fetch, redirect PC on a ready jump operand
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
            ir <= '0;
        end else if (state == S_FETCH && memRdy) begin
            ir <= inst;
            pc <= pc + ADDR_W'(1);
        end else if (state == S_JMP_TGT && memRdy) begin
            pc <= ADDR_W'(inst);
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            S_FETCH:   if (memRdy) next_state = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_HALT)
                    next_state = S_HALT;
                else if (opcode == OP_JMP)
                    next_state = S_JMP_TGT;
`ifdef CTRL_ILLEGAL_TRAP_EN
                else if (undef_op)
                    next_state = S_HALT;
`endif
                else
                    next_state = S_EX1;
            end
            S_JMP_TGT: if (memRdy) next_state = S_FETCH;
            S_EX1:     next_state = (opcode == OP_ALU) ? S_EX2 : S_FETCH;
            S_EX2:     next_state = S_FETCH;
            S_HALT:    next_state = S_HALT;
            default:   next_state = S_FETCH;
        endcase
    end

    // Output decode from state and IR; memRd stays low while reset is held
    always_comb begin
        memRd    = 1'b0;
        regSel   = '0;
        aluSel   = '0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        RAin     = 1'b0;
        RCout    = 1'b0;
        genConst = 1'b0;
        halted   = 1'b0;
        unique case (state)
            S_FETCH, S_JMP_TGT: memRd = !rst;
            S_HALT:             halted = 1'b1;
            S_EX1: begin
                case (opcode)
                    OP_MOVA: begin
                        regSel = operand;
                        Rout   = 1'b1;
                        RAin   = 1'b1;
                    end
                    OP_ALU: begin
                        aluSel = operand;
                        Rout   = 1'b1;
                    end
                    OP_LDC: begin
                        regSel   = operand;
                        genConst = 1'b1;
                        RAin     = 1'b1;
                    end
                    OP_MOVR: begin
                        regSel = operand;
                        RCout  = 1'b1;
                        Rin    = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_EX2: begin
                aluSel = operand;
                RCout  = 1'b1;
                Rin    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit_mc.sv
// Directed table-driven bench for control_unit_mc: one vector per clock cycle,
// holding the inputs for that cycle and the outputs expected in that cycle,
// plus hand-written sequences for mid-instruction reset and undefined opcodes.
module tb_control_unit_mc;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] inst;
    logic       memRdy;
    logic [7:0] memAddr;
    logic       memRd;
    logic [2:0] regSel;
    logic [2:0] aluSel;
    logic       Rin, Rout, RAin, RCout, genConst, halted, illegal;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    control_unit_mc #(.ADDR_W(8), .INST_W(8), .SEL_W(3)) dut (
        .clk(clk), .rst(rst), .inst(inst), .memRdy(memRdy),
        .memAddr(memAddr), .memRd(memRd), .regSel(regSel), .aluSel(aluSel),
        .Rin(Rin), .Rout(Rout), .RAin(RAin), .RCout(RCout),
        .genConst(genConst), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // strb = {Rin, Rout, RAin, RCout, genConst}
    typedef struct packed {
        logic [7:0] inst;
        logic       rdy;
        logic [7:0] addr;
        logic       rd;
        logic [2:0] rsel;
        logic [2:0] asel;
        logic [4:0] strb;
        logic       hlt;
        logic       ill;
    } vec_t;

    localparam int N_VEC = 34;
    vec_t tbl [N_VEC];

    function automatic logic [21:0] observed();
        return {memAddr, memRd, regSel, aluSel,
                Rin, Rout, RAin, RCout, genConst, halted, illegal};
    endfunction

    task automatic check(input string name, input logic [21:0] exp);
        logic [21:0] act;
        act = observed();
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got addr=%h rd=%b rsel=%0d asel=%0d strb=%b hlt=%b ill=%b (raw %h), expected raw %h",
                     name, act[21:14], act[13], act[12:10], act[9:7], act[6:2],
                     act[1], act[0], act, exp);
    endtask

    function automatic logic [21:0] pk(input logic [7:0] addr, input logic rd,
                                       input logic [2:0] rs, input logic [2:0] as,
                                       input logic [4:0] st, input logic h,
                                       input logic il);
        return {addr, rd, rs, as, st, h, il};
    endfunction

    // Drive one cycle's inputs just after a falling edge, check, then advance
    task automatic cycle(input logic [7:0] i, input logic r, input string name,
                         input logic [21:0] exp);
        inst   = i;
        memRdy = r;
        #1;
        check(name, exp);
        @(negedge clk);
    endtask

    initial begin
        // FETCH 0: MOVA r3
        tbl[0]  = '{8'h0B, 1'b1, 8'h00, 1'b1, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0};
        tbl[1]  = '{8'hFF, 1'b1, 8'h01, 1'b0, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0};
        tbl[2]  = '{8'hFF, 1'b1, 8'h01, 1'b0, 3'd3, 3'd0, 5'b01100, 1'b0, 1'b0};
        // FETCH 1: ALU f=5
        tbl[3]  = '{8'h15, 1'b1, 8'h01, 1'b1, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0};
        tbl[4]  = '{8'h00, 1'b0, 8'h02, 1'b0, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0};
        tbl[5]  = '{8'h00, 1'b1, 8'h02, 1'b0, 3'd0, 3'd5, 5'b01000, 1'b0, 1'b0};
        tbl[6]  = '{8'h00, 1'b1, 8'h02, 1'b0, 3'd0, 3'd5, 5'b10010, 1'b0, 1'b0};
        // FETCH 2 stalled three cycles
        tbl[7]  = '{8'hFF, 1'b0, 8'h02, 1'b1, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0};
        tbl[8]  = '{8'hFF, 1'b0, 8'h02, 1'b1, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0};
        tbl[9]  = '{8'hFF, 1'b0, 8'h02, 1'b1, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0};
        // LDC 7
        tbl[10] = '{8'h1F, 1'b1, 8'h02, 1'b1, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0};
        tbl[11] = '{8'h00, 1'b1, 8'h03, 1'b0, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0};
        tbl[12] = '{8'h00, 1'b1, 8'h03, 1'b0, 3'd7, 3'd0, 5'b00101, 1'b0, 1'b0};
        // MOVR r2
        tbl[13] = '{8'h22, 1'b1, 8'h03, 1'b1, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0};
        tbl[14] = '{8'h00, 1'b1, 8'h04, 1'b0, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0};
        tbl[15] = '{8'h00, 1'b1, 8'h04, 1'b0, 3'd2, 3'd0, 5'b10010, 1'b0, 1'b0};
        // NOP
        tbl[16] = '{8'h00, 1'b1, 8'h04, 1'b1, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0};
        tbl[17] = '{8'hFF, 1'b1, 8'h05, 1'b0, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0};
        tbl[18] = '{8'hFF, 1'b1, 8'h05, 1'b0, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0};
        // JMP 0x40, operand stalled one cycle
        tbl[19] = '{8'h28, 1'b1, 8'h05, 1'b1, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0};
        tbl[20] = '{8'h40, 1'b1, 8'h06, 1'b0, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0};
        tbl[21] = '{8'h77, 1'b0, 8'h06, 1'b1, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0};
        tbl[22] = '{8'h40, 1'b1, 8'h06, 1'b1, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0};
        // FETCH 0x40: JMP 0xFF
        tbl[23] = '{8'h28, 1'b1, 8'h40, 1'b1, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0};
        tbl[24] = '{8'h00, 1'b1, 8'h41, 1'b0, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0};
        tbl[25] = '{8'hFF, 1'b1, 8'h41, 1'b1, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0};
        // FETCH 0xFF: NOP, PC wraps to 0
        tbl[26] = '{8'h00, 1'b1, 8'hFF, 1'b1, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0};
        tbl[27] = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0};
        tbl[28] = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0};
        // FETCH 0: HALT, stays halted
        tbl[29] = '{8'hFF, 1'b1, 8'h00, 1'b1, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0};
        tbl[30] = '{8'h0B, 1'b1, 8'h01, 1'b0, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0};
        tbl[31] = '{8'h0B, 1'b1, 8'h01, 1'b0, 3'd0, 3'd0, 5'b00000, 1'b1, 1'b0};
        tbl[32] = '{8'h28, 1'b1, 8'h01, 1'b0, 3'd0, 3'd0, 5'b00000, 1'b1, 1'b0};
        tbl[33] = '{8'h00, 1'b0, 8'h01, 1'b0, 3'd0, 3'd0, 5'b00000, 1'b1, 1'b0};

        // Reset held with active-looking inputs
        rst    = 1'b1;
        inst   = 8'hFF;
        memRdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset", pk(8'h00, 1'b0, 3'd0, 3'd0, 5'b0, 1'b0, 1'b0));
        rst = 1'b0;

        for (int i = 0; i < N_VEC; i++)
            cycle(tbl[i].inst, tbl[i].rdy, $sformatf("vec%0d", i),
                  {tbl[i].addr, tbl[i].rd, tbl[i].rsel, tbl[i].asel,
                   tbl[i].strb, tbl[i].hlt, tbl[i].ill});

        // Reset out of HALT, then ALU with reset mid-EX2
        rst = 1'b1;
        #1;
        check("halt_reset", pk(8'h00, 1'b0, 3'd0, 3'd0, 5'b0, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b0;
        cycle(8'h15, 1'b1, "alu_fetch", pk(8'h00, 1'b1, 3'd0, 3'd0, 5'b0, 1'b0, 1'b0));
        cycle(8'h00, 1'b0, "alu_dec",   pk(8'h01, 1'b0, 3'd0, 3'd0, 5'b0, 1'b0, 1'b0));
        cycle(8'h00, 1'b0, "alu_ex1",   pk(8'h01, 1'b0, 3'd0, 3'd5, 5'b01000, 1'b0, 1'b0));
        inst = 8'h00;
        #1;
        check("alu_ex2", pk(8'h01, 1'b0, 3'd0, 3'd5, 5'b10010, 1'b0, 1'b0));
        rst = 1'b1;
        #1;
        check("mid_ex2_reset", pk(8'h00, 1'b0, 3'd0, 3'd0, 5'b0, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b0;

        // Undefined opcode 01000_000 fetched at address 0
        cycle(8'h40, 1'b1, "undef_fetch", pk(8'h00, 1'b1, 3'd0, 3'd0, 5'b0, 1'b0, 1'b0));
        cycle(8'h00, 1'b1, "undef_dec",   pk(8'h01, 1'b0, 3'd0, 3'd0, 5'b0, 1'b0, 1'b0));
`ifdef CTRL_ILLEGAL_TRAP_EN
        cycle(8'h00, 1'b1, "undef_trap",  pk(8'h01, 1'b0, 3'd0, 3'd0, 5'b0, 1'b1, 1'b1));
        cycle(8'h00, 1'b1, "undef_stay",  pk(8'h01, 1'b0, 3'd0, 3'd0, 5'b0, 1'b1, 1'b1));
`else
        cycle(8'h00, 1'b1, "undef_ex1",   pk(8'h01, 1'b0, 3'd0, 3'd0, 5'b0, 1'b0, 1'b0));
        cycle(8'h00, 1'b0, "undef_next",  pk(8'h01, 1'b1, 3'd0, 3'd0, 5'b0, 1'b0, 1'b0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
